// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and halt-drain control for the ID stage
// Optional stall-cycle statistic enabled by defining HAZARD_STALL_STATS_EN.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        useRsD,
  input  logic        useRtD,
  input  logic [4:0]  rwE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        StopD,
  input  logic        BranchTakenD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        isLWHazard,
  output logic        Halted,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] drain_cnt;
  logic [1:0] drain_cnt_nxt;
  logic       lu;
  logic       rs_match;
  logic       rt_match;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign rs_match = useRsD && (rsD == rwE);
  assign rt_match = useRtD && (rtD == rwE);
  assign lu       = RegWriteE && MemtoRegE && (rwE != 5'd0) && (rs_match || rt_match);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    StallF        = 1'b0;
    StallD        = 1'b0;
    FlushD        = 1'b0;
    isLWHazard    = 1'b0;
    Halted        = 1'b0;
    unique case (state)
      RUN: begin
        // Load-use wins: branch operands are not ready and the halt must wait
        if (lu) begin
          StallF     = 1'b1;
          StallD     = 1'b1;
          isLWHazard = 1'b1;
        end else if (StopD) begin
          StallF        = 1'b1;
          StallD        = 1'b1;
          state_nxt     = DRAIN;
          drain_cnt_nxt = 2'd3;
        end else if (BranchTakenD) begin
          FlushD = 1'b1;
        end
      end
      DRAIN: begin
        StallF        = 1'b1;
        StallD        = 1'b1;
        drain_cnt_nxt = drain_cnt - 2'd1;
        if (drain_cnt == 2'd1) begin
          state_nxt = HALTED;
        end
      end
      HALTED: begin
        StallF = 1'b1;
        StallD = 1'b1;
        Halted = 1'b1;
      end
      default: begin
        state_nxt     = RUN;
        drain_cnt_nxt = 2'd0;
      end
    endcase
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if ((state == RUN) && lu && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = 16'd0;
`endif

endmodule
